// File: rtl/crypto_host_if.sv
// Host-side initiator for the crypto core control unit: one request in flight.
// Optional wait-state timeout abort is enabled by defining CRYPTO_HOST_TIMEOUT_EN.
module crypto_host_if #(
    parameter int DATA_W      = 128,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_mode,
    input  logic [DATA_W-1:0] req_data,
    input  logic [DATA_W-1:0] req_key,
    output logic              core_bgn,
    output logic [1:0]        core_mode,
    output logic [DATA_W-1:0] core_din,
    output logic [DATA_W-1:0] core_kin,
    input  logic              core_ld,
    input  logic              core_out_data,
    input  logic              core_out_key,
    input  logic              core_fin,
    input  logic [DATA_W-1:0] core_bus,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [DATA_W-1:0] rsp_key,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_LD, WAIT_DATA, WAIT_KEY, WAIT_FIN, RESP
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] kin_q, kin_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic              err_q, err_d;
    logic              wait_st;

    assign wait_st = (state_q == WAIT_LD) || (state_q == WAIT_DATA) ||
                     (state_q == WAIT_KEY) || (state_q == WAIT_FIN);

`ifdef CRYPTO_HOST_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ?
                        $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo;

    assign tmo   = wait_st && (cnt_q == CW'(TIMEOUT_CYC));
    assign cnt_d = (state_d != state_q || !wait_st) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    logic tmo;
    logic unused_tmo_cfg;
    assign tmo            = 1'b0;
    assign unused_tmo_cfg = (TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 2'b00;
            din_q  <= '0;
            kin_q  <= '0;
            data_q <= '0;
            key_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            din_q  <= din_d;
            kin_q  <= kin_d;
            data_q <= data_d;
            key_q  <= key_d;
            err_q  <= err_d;
        end
    end

    // A premature core_fin aborts the wait; uncaptured fields stay zero.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        din_d   = din_q;
        kin_d   = kin_q;
        data_d  = data_q;
        key_d   = key_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: if (req_valid) begin
                mode_d = req_mode;
                din_d  = req_data;
                kin_d  = req_key;
                data_d = '0;
                key_d  = '0;
                if (req_mode == 2'b01 || req_mode == 2'b10) begin
                    state_d = ISSUE;
                    err_d   = 1'b0;
                end else begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end
            end
            ISSUE: state_d = WAIT_LD;
            WAIT_LD: begin
                if (core_fin) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else if (core_ld) begin
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (core_fin) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else if (core_out_data) begin
                    data_d  = core_bus;
                    state_d = WAIT_KEY;
                    if (core_out_key) err_d = 1'b1;
                end else if (core_out_key) begin
                    err_d = 1'b1;
                end
            end
            WAIT_KEY: begin
                if (core_fin) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else if (core_out_key) begin
                    key_d   = core_bus;
                    state_d = WAIT_FIN;
                end
            end
            WAIT_FIN: if (core_fin) state_d = RESP;
            RESP: if (rsp_ready) begin
                state_d = IDLE;
                mode_d  = 2'b00;
            end
            default: state_d = IDLE;
        endcase
        if (tmo && state_d == state_q) begin
            state_d = RESP;
            err_d   = 1'b1;
        end
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        core_bgn  = (state_q == ISSUE);
        rsp_valid = (state_q == RESP);
        busy      = (state_q != IDLE);
        core_mode = mode_q;
        core_din  = din_q;
        core_kin  = kin_q;
        rsp_data  = data_q;
        rsp_key   = key_q;
        rsp_err   = err_q;
    end

endmodule
